// File: rtl/conv_pool_quantize.sv
// conv_pool_quantize
//   Requantizes a vector of signed 32-bit convolution results to unsigned
//   8-bit pixels (ReLU, round-half-up right shift, saturate to 255). It then
//   applies a 2x2 non-overlapping max-pool over the raster-ordered stream.
//   Each of the NUM_TREES lanes is processed independently.
//
//   Parameters
//     NUM_TREES  : parallel kernel outputs per input vector
//     SHIFT      : requantization right shift (0..16)
//     IMG_WIDTH  : conv output columns per row (even, >= 2)
//     IMG_HEIGHT : conv output rows per frame (even, >= 2)
//
//   Ports
//     clock            : rising-edge clock
//     reset            : asynchronous active-low reset
//     pixel_vector_in  : NUM_TREES x signed 32-bit, tree k at [32k+31:32k]
//     valid_in         : qualifies pixel_vector_in
//     pixel_vector_out : NUM_TREES x unsigned 8-bit, tree k at [8k+7:8k]
//     valid_out        : one-cycle strobe qualifying pixel_vector_out
//     frame_done       : strobe coincident with the last pooled output of a frame
module conv_pool_quantize #(
    parameter int NUM_TREES  = 2,
    parameter int SHIFT      = 4,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [32*NUM_TREES-1:0]  pixel_vector_in,
    input  logic                     valid_in,
    output logic [8*NUM_TREES-1:0]   pixel_vector_out,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int CW       = $clog2(IMG_WIDTH);
    localparam int RW       = $clog2(IMG_HEIGHT);
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    // Half an LSB of the shifted result; evaluates to zero when SHIFT is 0.
    localparam logic [32:0]   RND      = (33'd1 << SHIFT) >> 1;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    // ReLU, rounded right shift in 33 bits, then clamp to 8 bits.
    function automatic logic [7:0] requant(input logic signed [31:0] x);
        logic [32:0] sum;
        logic [32:0] shifted;
        logic [7:0]  r;
        sum     = {1'b0, x} + RND;
        shifted = sum >> SHIFT;
        if (x < 0)
            r = 8'd0;
        else if (shifted > 33'd255)
            r = 8'd255;
        else
            r = shifted[7:0];
        return r;
    endfunction

    function automatic logic [7:0] umax8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? a : b;
    endfunction

    logic [8*NUM_TREES-1:0] q_p1;
    logic                   vld_p1;

    logic [CW-1:0]          col_p2;
    logic [RW-1:0]          row_p2;
    state_t                 state_p2;
    logic [8*NUM_TREES-1:0] hold_p2;
    logic [8*NUM_TREES-1:0] linebuf_p2 [LB_DEPTH];

    logic [LW-1:0]          lb_idx;
    logic [8*NUM_TREES-1:0] hmax;
    logic [8*NUM_TREES-1:0] pool;

    // ---- stage 1: requantize ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= valid_in;
            if (valid_in) begin
                for (int k = 0; k < NUM_TREES; k++)
                    q_p1[8*k +: 8] <= requant($signed(pixel_vector_in[32*k +: 32]));
            end
        end
    end

    // ---- stage 2: 2x2 max-pool ----
    assign lb_idx = LW'(col_p2 >> 1);

    always_comb begin
        hmax = '0;
        pool = '0;
        for (int k = 0; k < NUM_TREES; k++) begin
            hmax[8*k +: 8] = umax8(hold_p2[8*k +: 8], q_p1[8*k +: 8]);
            pool[8*k +: 8] = umax8(linebuf_p2[lb_idx][8*k +: 8], hmax[8*k +: 8]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_p2           <= '0;
            row_p2           <= '0;
            state_p2         <= EVEN_ROW;
            hold_p2          <= '0;
            pixel_vector_out <= '0;
            valid_out        <= 1'b0;
            frame_done       <= 1'b0;
            for (int i = 0; i < LB_DEPTH; i++)
                linebuf_p2[i] <= '0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (vld_p1) begin
                if (!col_p2[0]) begin
                    hold_p2 <= q_p1;
                end else if (state_p2 == EVEN_ROW) begin
                    linebuf_p2[lb_idx] <= hmax;
                end else begin
                    pixel_vector_out <= pool;
                    valid_out        <= 1'b1;
                    frame_done       <= (row_p2 == ROW_LAST) && (col_p2 == COL_LAST);
                end

                // Column wrap moves to the next row; the row parity is tracked by the FSM.
                if (col_p2 == COL_LAST) begin
                    col_p2   <= '0;
                    state_p2 <= (state_p2 == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                    row_p2   <= (row_p2 == ROW_LAST) ? '0 : row_p2 + 1'b1;
                end else begin
                    col_p2 <= col_p2 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_quantize.sv
// Directed bench for conv_pool_quantize on a 4x2 image with two trees.
// Instance dut0 runs with SHIFT=0 and dut4 runs with SHIFT=4. Both receive
// the same stimulus, and each test checks the instance that its expected
// values were hand-computed for.
module tb_conv_pool_quantize;

    localparam int NT = 2;
    localparam int W  = 4;
    localparam int H  = 2;

    logic              clock;
    logic              reset;
    logic [32*NT-1:0]  pixel_vector_in;
    logic              valid_in;
    logic [8*NT-1:0]   out0, out4;
    logic              vo0, vo4, fd0, fd4;

    int cyc;
    int n_vec;
    int n_err;

    typedef struct {
        logic [15:0] d;
        logic        fd;
        int          cyc;
    } ev_t;

    ev_t q0[$];
    ev_t q4[$];
    int  br[$];

    logic signed [31:0] fa [8];
    logic signed [31:0] fb [8];

    conv_pool_quantize #(.NUM_TREES(NT), .SHIFT(0), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut0 (
        .clock(clock), .reset(reset), .pixel_vector_in(pixel_vector_in), .valid_in(valid_in),
        .pixel_vector_out(out0), .valid_out(vo0), .frame_done(fd0));

    conv_pool_quantize #(.NUM_TREES(NT), .SHIFT(4), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut4 (
        .clock(clock), .reset(reset), .pixel_vector_in(pixel_vector_in), .valid_in(valid_in),
        .pixel_vector_out(out4), .valid_out(vo4), .frame_done(fd4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Log every strobe of either output, sampled on the falling edge.
    always @(negedge clock) begin
        if (vo0 || fd0) q0.push_back('{d: out0, fd: fd0, cyc: cyc});
        if (vo4 || fd4) q4.push_back('{d: out4, fd: fd4, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic send_pix(input logic signed [31:0] a, input logic signed [31:0] b,
                            input int gap, output int dcyc);
        pixel_vector_in = {b, a};
        valid_in        = 1'b1;
        dcyc            = cyc;
        @(negedge clock);
        valid_in = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_frame(input int gap);
        int dc;
        for (int i = 0; i < 8; i++) begin
            send_pix(fa[i], fb[i], gap, dc);
            // Bottom-right pixels of the two windows in a 4x2 frame.
            if (i == 5 || i == 7) br.push_back(dc);
        end
    endtask

    task automatic clear_logs();
        q0.delete();
        q4.delete();
        br.delete();
    endtask

    task automatic load_basic();
        for (int i = 0; i < 8; i++) begin
            fa[i] = i;
            fb[i] = 10 * i;
        end
    endtask

    // Checks the two strobes of one basic frame at the head of q0 (outputs 5/50 then 7/70).
    task automatic check_basic(input string tag);
        ev_t e;
        int  b;
        chk({tag, "_count"}, q0.size(), 2);
        if (q0.size() == 2 && br.size() == 2) begin
            e = q0.pop_front(); b = br.pop_front();
            chk({tag, "_out0"}, e.d, {8'd50, 8'd5});
            chk({tag, "_fd0"}, e.fd, 0);
            chk({tag, "_lat0"}, e.cyc - b, 2);
            e = q0.pop_front(); b = br.pop_front();
            chk({tag, "_out1"}, e.d, {8'd70, 8'd7});
            chk({tag, "_fd1"}, e.fd, 1);
            chk({tag, "_lat1"}, e.cyc - b, 2);
        end
    endtask

    initial begin
        logic [7:0] exp_q [6];
        ev_t e;
        int  dc;

        cyc             = 0;
        n_vec           = 0;
        n_err           = 0;
        valid_in        = 1'b0;
        pixel_vector_in = '0;
        reset           = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_out", out0, 0);
        chk("rst_valid", vo0, 0);
        chk("rst_fd", fd0, 0);
        chk("rst_out4", out4, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Basic pool with tree1 = 10*tree0 at SHIFT=0.
        clear_logs();
        load_basic();
        send_frame(0);
        repeat (4) @(negedge clock);
        check_basic("basic");

        // Same frame with three idle cycles after every pixel.
        clear_logs();
        send_frame(3);
        repeat (4) @(negedge clock);
        check_basic("gap");

        // Requantize, saturation and ReLU at SHIFT=4, three frames back to back.
        clear_logs();
        fa = '{24, 24, 1596, 1596, 24, 24, 1596, 1596};
        fb = fa;
        send_frame(0);
        fa = '{5000, 5000, 32'hFFFFFFF0, 0, 5000, 5000, 0, 0};
        fb = fa;
        send_frame(0);
        fa = '{-100, 48, 32'h7FFFFFFF, 32'h7FFFFFFF, -5, 0, 32'h7FFFFFFF, 32'h7FFFFFFF};
        fb = fa;
        send_frame(0);
        repeat (4) @(negedge clock);
        exp_q = '{8'd2, 8'd100, 8'd255, 8'd0, 8'd3, 8'd255};
        chk("rq_count", q4.size(), 6);
        if (q4.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                e = q4.pop_front();
                chk($sformatf("rq_out%0d", i), e.d, {exp_q[i], exp_q[i]});
                chk($sformatf("rq_fd%0d", i), e.fd, (i % 2));
            end
        end
        chk("rq_hold_out", out4, {8'd255, 8'd255});
        chk("rq_hold_valid", vo4, 0);

        // Reset after five pixels of a frame, then replay the basic frame.
        clear_logs();
        load_basic();
        for (int i = 0; i < 5; i++) send_pix(fa[i], fb[i], 0, dc);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_out", out0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("mid_rst_stale", q0.size(), 0);
        clear_logs();
        send_frame(0);
        repeat (4) @(negedge clock);
        check_basic("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
